// File: rtl/keypad_pkg.sv
// Shared constants, FSM states and column decode for the matrix keypad scanner.
package keypad_pkg;

  localparam logic [3:0] ROW0 = 4'b0111;
  localparam logic [3:0] ROW1 = 4'b1011;
  localparam logic [3:0] ROW2 = 4'b1101;
  localparam logic [3:0] ROW3 = 4'b1110;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} db_state_t;

  // Candidate is {valid, row_idx, col_idx}; bit 4 clear means no key.
  localparam logic [4:0] CAND_NONE = 5'b0_0000;

  typedef struct packed {
    logic       vld;
    logic [1:0] col;
  } col_dec_t;

  // Lowest col_idx wins when several lines are pulled low.
  function automatic col_dec_t decode_col(input logic [3:0] col);
    col_dec_t d;
    d.vld = 1'b1;
    d.col = 2'd0;
    if      (!col[3]) d.col = 2'd0;
    else if (!col[2]) d.col = 2'd1;
    else if (!col[1]) d.col = 2'd2;
    else if (!col[0]) d.col = 2'd3;
    else              d.vld = 1'b0;
    return d;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = ROW0;
      2'd1:    r = ROW1;
      2'd2:    r = ROW2;
      default: r = ROW3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Row divider and rotation; strobes the last dwell cycle of each row and flags frame end on row 3.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] keypad_row,
  output logic [1:0] row_idx,
  output logic       sample,
  output logic       frame_end
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      row_idx <= 2'd0;
    end else if (sample) begin
      div     <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      div     <= div + DIV_W'(1);
    end
  end

  assign sample     = (div == DIV_LAST);
  assign frame_end  = sample && (row_idx == 2'd3);
  assign keypad_row = row_drive(row_idx);

endmodule

// File: rtl/keypad_debouncer.sv
// Scans the 4x4 keypad, picks one candidate key per frame and debounces press/release over frames.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  logic [1:0] row_idx;
  logic       sample;
  logic       frame_end;

  keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .reset     (reset),
    .keypad_row(keypad_row),
    .row_idx   (row_idx),
    .sample    (sample),
    .frame_end (frame_end)
  );

  col_dec_t   dec;
  logic [4:0] hit;
  logic [4:0] base;
  logic [4:0] frame_cand;
  logic [4:0] cand_q;

  // Row 0 starts a fresh frame; earlier rows keep priority over later ones.
  always_comb begin
    dec        = decode_col(keypad_col);
    hit        = dec.vld ? {1'b1, row_idx, dec.col} : CAND_NONE;
    base       = (row_idx == 2'd0) ? CAND_NONE : cand_q;
    frame_cand = base[4] ? base : hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cand_q <= CAND_NONE;
    else if (sample) cand_q <= frame_end ? CAND_NONE : frame_cand;
  end

  db_state_t  state, state_n;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic [3:0] tracked, tracked_n;
  logic [3:0] code_n;
  logic       held_n, valid_n;
  logic       match_trk, match_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      tracked   <= 4'd0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tracked   <= tracked_n;
      key_code  <= code_n;
      key_held  <= held_n;
      key_valid <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tracked_n  = tracked;
    code_n     = key_code;
    held_n     = key_held;
    valid_n    = 1'b0;
    cnt_inc    = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    match_trk  = (frame_cand == {1'b1, tracked});
    match_code = (frame_cand == {1'b1, key_code});
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_cand[4]) begin
            tracked_n = frame_cand[3:0];
            if (DB_TARGET <= 4'd1) begin
              state_n = HELD;
              cnt_n   = 4'd0;
              code_n  = frame_cand[3:0];
              held_n  = 1'b1;
              valid_n = 1'b1;
            end else begin
              state_n = PRESS_DB;
              cnt_n   = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (!match_trk) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end else if (cnt_inc >= DB_TARGET) begin
            state_n = HELD;
            cnt_n   = 4'd0;
            code_n  = tracked;
            held_n  = 1'b1;
            valid_n = 1'b1;
          end else begin
            cnt_n   = cnt_inc;
          end
        end
        HELD: begin
          if (!match_code) begin
            if (DB_TARGET <= 4'd1) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
              held_n  = 1'b0;
            end else begin
              state_n = RELEASE_DB;
              cnt_n   = 4'd1;
            end
          end
        end
        RELEASE_DB: begin
          if (match_code) begin
            state_n = HELD;
            cnt_n   = 4'd0;
          end else if (cnt_inc >= DB_TARGET) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            held_n  = 1'b0;
          end else begin
            cnt_n   = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench: SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame is 16 cycles.
module tb_keypad_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keypad_col;
  logic [3:0] keypad_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  keypad_debouncer #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .keypad_col(keypad_col),
    .keypad_row(keypad_row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    keypad_col = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!keypad_row[3-r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) keypad_col[3-c] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic [3:0]  code;
    int          pulses;
    logic        held;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frames(input int n, output int p);
    p = 0;
    repeat (n * 16) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) p++;
    end
  endtask

  task automatic chk_state(input string tag, input int p, input logic [3:0] code,
                           input int ep, input logic held);
    chk({tag, ".code"},   32'(key_code), 32'(code));
    chk({tag, ".pulses"}, 32'(p),        32'(ep));
    chk({tag, ".held"},   32'(key_held), 32'(held));
  endtask

  initial begin
    int p;
    logic [3:0] exp_row;
    vecs[0]  = '{16'h0000, 1,  4'd0, 0, 1'b0};
    vecs[1]  = '{16'h0040, 2,  4'd6, 1, 1'b1};
    vecs[2]  = '{16'h0000, 1,  4'd6, 0, 1'b1};
    vecs[3]  = '{16'h0040, 1,  4'd6, 0, 1'b1};
    vecs[4]  = '{16'h0000, 2,  4'd6, 0, 1'b0};
    vecs[5]  = '{16'h0040, 1,  4'd6, 0, 1'b0};
    vecs[6]  = '{16'h0000, 1,  4'd6, 0, 1'b0};
    vecs[7]  = '{16'h0040, 1,  4'd6, 0, 1'b0};
    vecs[8]  = '{16'h0000, 1,  4'd6, 0, 1'b0};
    vecs[9]  = '{16'h0150, 2,  4'd4, 1, 1'b1};
    vecs[10] = '{16'h0000, 2,  4'd4, 0, 1'b0};
    vecs[11] = '{16'h0001, 2,  4'd0, 1, 1'b1};
    vecs[12] = '{16'h8000, 2,  4'd0, 0, 1'b0};
    vecs[13] = '{16'h8000, 2, 4'd15, 1, 1'b1};
    vecs[14] = '{16'h0000, 2, 4'd15, 0, 1'b0};

    keys  = 16'h0000;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst.row",   32'(keypad_row), 32'(4'b0111));
    chk("rst.code",  32'(key_code),   32'd0);
    chk("rst.valid", 32'(key_valid),  32'd0);
    chk("rst.held",  32'(key_held),   32'd0);
    @(negedge clk) reset = 1'b1;

    // Full rotation: each row dwells 4 cycles, row 0 through row 3 and back.
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_row = 4'b1111 ^ (4'b1000 >> ((k / 4) % 4));
      chk($sformatf("rot%0d.row", k), 32'(keypad_row), 32'(exp_row));
    end

    for (int i = 0; i < 15; i++) begin
      keys = vecs[i].keys;
      run_frames(vecs[i].frames, p);
      chk_state($sformatf("vec%0d", i), p, vecs[i].code, vecs[i].pulses, vecs[i].held);
    end

    // A press interrupted by reset must restart its debounce from scratch.
    keys = 16'h0200;
    run_frames(1, p);
    chk("rstpress.pre.pulses", 32'(p), 32'd0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstpress.row",   32'(keypad_row), 32'(4'b0111));
    chk("rstpress.code",  32'(key_code),   32'd0);
    chk("rstpress.valid", 32'(key_valid),  32'd0);
    @(negedge clk) reset = 1'b1;
    run_frames(1, p);
    chk_state("rstpress.f1", p, 4'd0, 0, 1'b0);
    run_frames(1, p);
    chk_state("rstpress.f2", p, 4'd9, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
